address_bus_arbiter: RTL

//  Parametrised N-master arbiter and registered driver for the shared memory address bus.
//  - Replaces the point-to-point in/out address hookup between PC, IR and CPU with one owner per transaction.
//  - Masters (index 0 = PC, 1 = IR, 2 = CPU by default) request the bus.
//  - Exactly one address is issued to memory with a valid/ready handshake.
//  - Arbitration is fixed-priority or round-robin.
//

---
 rtl/address_bus_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/address_bus_arbiter.sv
// address_bus_arbiter: N-master arbiter and registered driver for the shared
// memory address bus. It issues one address at a time with a valid/ready
// handshake. Arbitration is fixed priority (lowest index wins) or round-robin.
//
// state | meaning
// IDLE  | no transaction outstanding, mem_valid low
// BUSY  | mem_addr/mem_owner presented with mem_valid high, waiting for mem_ready
module address_bus_arbiter #(
  parameter int ADDR_W      = 19,
  parameter int NUM_MASTERS = 3,
  parameter bit RR_MODE     = 1'b0,
  localparam int OW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_MASTERS-1:0]        req_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] req_addr_i,
  output logic [NUM_MASTERS-1:0]        gnt_o,
  output logic [NUM_MASTERS-1:0]        done_o,
  output logic [ADDR_W-1:0]             mem_addr_o,
  output logic                          mem_valid_o,
  input  logic                          mem_ready_i,
  output logic [OW-1:0]                 mem_owner_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q;
  logic [NUM_MASTERS-1:0] gnt_q;
  logic [NUM_MASTERS-1:0] done_q;
  logic [ADDR_W-1:0]      mem_addr_q;
  logic                   mem_valid_q;
  logic [OW-1:0]          owner_q;
  logic [OW-1:0]          rr_ptr_q;

  logic                   complete;
  logic [NUM_MASTERS-1:0] done_vec;
  logic [NUM_MASTERS-1:0] elig;
  logic                   win_found;
  logic [OW-1:0]          win_idx;
  logic [ADDR_W-1:0]      win_addr;
  logic [OW-1:0]          rr_ptr_d;

  // Completing master is masked out so it cannot be re-granted on its own done edge
  always_comb begin
    complete = (state_q == BUSY) && mem_ready_i;
    done_vec = '0;
    if (complete) done_vec[owner_q] = 1'b1;
    elig = req_i & ~done_vec;
  end

  // Winner search: from index 0 (fixed) or from the RR pointer with wrap (round-robin)
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (RR_MODE) j = (int'(rr_ptr_q) + k) % NUM_MASTERS;
      else         j = k;
      if (!win_found && elig[j]) begin
        win_found = 1'b1;
        win_idx   = OW'(j);
      end
    end
    win_addr = req_addr_i[win_idx*ADDR_W +: ADDR_W];
    rr_ptr_d = (int'(win_idx) == NUM_MASTERS - 1) ? '0 : win_idx + 1'b1;
  end

  // Transaction FSM with registered handshake, grant and done outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      mem_addr_q  <= '0;
      mem_valid_q <= 1'b0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= done_vec;
      if (state_q == IDLE || complete) begin
        if (win_found) begin
          mem_addr_q     <= win_addr;
          owner_q        <= win_idx;
          mem_valid_q    <= 1'b1;
          gnt_q[win_idx] <= 1'b1;
          rr_ptr_q       <= rr_ptr_d;
          state_q        <= BUSY;
        end else begin
          mem_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      end
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_valid_o = mem_valid_q;
  assign mem_owner_o = owner_q;

endmodule
